// File: rtl/sram_record_writer.sv
// sram_record_writer
//   Record-path SRAM writer for the audio recorder. While the top-level FSM is
//   in RECORD, each 16-bit sample pulsed in by the I2S receiver is written to
//   the next SRAM address, starting at 0. Every write has three phases:
//   setup (address/data driven, WE_N high), strobe (WE_N low), hold (WE_N high).
//   The address of the last committed sample is published for the playback reader.
//
// Parameters
//   MAX_ADDR            highest SRAM address the writer may use
// Ports
//   i_clk               system clock (12 MHz)
//   i_rst_n             asynchronous active-low reset
//   i_state [2:0]       top FSM state: 000 IDLE, 001 PLAY, 010 RECORD, 011 PAUSE
//                       (other codes behave as IDLE)
//   i_write_enable      one-cycle sample strobe from I2S
//   i_write_data [15:0] PCM sample, valid with i_write_enable
//   SRAM_ADDR [19:0]    SRAM address
//   o_sram_dq [15:0]    SRAM write data
//   o_sram_dq_oe        DQ tristate enable
//   o_sram_ctrl [4:0]   {WE_N, CE_N, OE_N, LB_N, UB_N}
//   o_write_done        one-cycle pulse when a sample is committed
//   o_record_end_addr   address of the last committed sample
//   o_mem_full          set once MAX_ADDR has been written
//   o_overrun           sticky dropped-sample flag (only with SRAM_WR_OVERRUN_EN)
//
// Build option
//   SRAM_WR_OVERRUN_EN  adds the o_overrun port and its sticky logic.

module sram_record_writer #(
    parameter logic [19:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_state,
    input  logic        i_write_enable,
    input  logic [15:0] i_write_data,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] o_sram_dq,
    output logic        o_sram_dq_oe,
    output logic [4:0]  o_sram_ctrl,
    output logic        o_write_done,
    output logic [19:0] o_record_end_addr,
    output logic        o_mem_full
`ifdef SRAM_WR_OVERRUN_EN
    ,
    output logic        o_overrun
`endif
);

    localparam logic [2:0] ST_RECORD = 3'b010;
    localparam logic [2:0] ST_PAUSE  = 3'b011;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD
    } wstate_e;

    wstate_e     state_q, state_d;
    logic        rec_or_pause_q, rec_or_pause_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] dq_q, dq_d;
    logic        oe_q, oe_d;
    logic        we_n_q, we_n_d;
    logic        done_q, done_d;
    logic [19:0] end_addr_q, end_addr_d;
    logic        full_q, full_d;
`ifdef SRAM_WR_OVERRUN_EN
    logic        ovr_q, ovr_d;
`endif

    logic in_record;
    logic new_rec;
    logic accept;

    always_comb begin
        in_record = (i_state == ST_RECORD);
        // A recording only restarts when RECORD is entered from something other
        // than RECORD/PAUSE; resuming from PAUSE keeps the address running.
        new_rec   = in_record && !rec_or_pause_q;
        // The full flag is being cleared by a new recording in this same cycle,
        // so a pulse coinciding with it is still taken.
        accept    = (state_q == W_IDLE) && i_write_enable && in_record &&
                    (new_rec || !full_q);

        rec_or_pause_d = in_record || (i_state == ST_PAUSE);
        state_d        = state_q;
        addr_d         = addr_q;
        dq_d           = dq_q;
        end_addr_d     = end_addr_q;
        full_d         = full_q;
`ifdef SRAM_WR_OVERRUN_EN
        ovr_d          = ovr_q;
`endif

        unique case (state_q)
            W_IDLE:   if (accept) state_d = W_SETUP;
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: state_d = W_HOLD;
            W_HOLD:   state_d = W_IDLE;
            default:  state_d = W_IDLE;
        endcase

        if (accept)
            dq_d = i_write_data;

        // End address becomes visible together with the done pulse (HOLD).
        if (state_q == W_STROBE)
            end_addr_d = addr_q;

        // Advance at the end of HOLD; the last address is never left.
        if (state_q == W_HOLD) begin
            if (addr_q == MAX_ADDR)
                full_d = 1'b1;
            else
                addr_d = addr_q + 20'd1;
        end

        if (new_rec) begin
            addr_d     = '0;
            end_addr_d = '0;
            full_d     = 1'b0;
`ifdef SRAM_WR_OVERRUN_EN
            ovr_d      = 1'b0;
`endif
        end

`ifdef SRAM_WR_OVERRUN_EN
        // Only a busy writer counts as an overrun; a full memory drops silently.
        if (i_write_enable && in_record && (state_q != W_IDLE))
            ovr_d = 1'b1;
`endif

        // Output flops are loaded from the next state so every pin is registered
        // yet lines up with the FSM phase.
        oe_d   = (state_d != W_IDLE);
        we_n_d = (state_d != W_STROBE);
        done_d = (state_d == W_HOLD);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= W_IDLE;
            rec_or_pause_q <= 1'b0;
            addr_q         <= '0;
            dq_q           <= '0;
            oe_q           <= 1'b0;
            we_n_q         <= 1'b1;
            done_q         <= 1'b0;
            end_addr_q     <= '0;
            full_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rec_or_pause_q <= rec_or_pause_d;
            addr_q         <= addr_d;
            dq_q           <= dq_d;
            oe_q           <= oe_d;
            we_n_q         <= we_n_d;
            done_q         <= done_d;
            end_addr_q     <= end_addr_d;
            full_q         <= full_d;
        end
    end

`ifdef SRAM_WR_OVERRUN_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ovr_q <= 1'b0;
        else          ovr_q <= ovr_d;
    end
    assign o_overrun = ovr_q;
`endif

    assign SRAM_ADDR         = addr_q;
    assign o_sram_dq         = dq_q;
    assign o_sram_dq_oe      = oe_q;
    // CE_N and LB_N/UB_N stay active, OE_N stays inactive: only WE_N toggles.
    assign o_sram_ctrl       = {we_n_q, 4'b0100};
    assign o_write_done      = done_q;
    assign o_record_end_addr = end_addr_q;
    assign o_mem_full        = full_q;

endmodule

// File: tb/tb_sram_record_writer.sv
// Randomised self-checking bench for sram_record_writer (MAX_ADDR = 3).
module tb_sram_record_writer;

    localparam logic [19:0] MAX = 20'h00003;
    localparam logic [2:0] S_IDLE = 3'b000, S_PLAY = 3'b001, S_REC = 3'b010, S_PAUSE = 3'b011;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [2:0]  i_state;
    logic        i_write_enable;
    logic [15:0] i_write_data;
    logic [19:0] SRAM_ADDR;
    logic [15:0] o_sram_dq;
    logic        o_sram_dq_oe;
    logic [4:0]  o_sram_ctrl;
    logic        o_write_done;
    logic [19:0] o_record_end_addr;
    logic        o_mem_full;
`ifdef SRAM_WR_OVERRUN_EN
    logic        o_overrun;
`endif

    sram_record_writer #(.MAX_ADDR(MAX)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_state(i_state),
        .i_write_enable(i_write_enable), .i_write_data(i_write_data),
        .SRAM_ADDR(SRAM_ADDR), .o_sram_dq(o_sram_dq), .o_sram_dq_oe(o_sram_dq_oe),
        .o_sram_ctrl(o_sram_ctrl), .o_write_done(o_write_done),
        .o_record_end_addr(o_record_end_addr), .o_mem_full(o_mem_full)
`ifdef SRAM_WR_OVERRUN_EN
        , .o_overrun(o_overrun)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: a sample accepted at edge T is set up after T, strobed
    // after T+1, committed (done, end address) after T+2 and the writer is free
    // again after T+3. Expected SRAM writes are queued in acceptance order.
    typedef struct { logic [19:0] a; logic [15:0] d; } wr_t;
    wr_t wq[$];

    int          ecnt, t_acc;
    bit          acc_valid;
    logic [19:0] m_addr, m_end;
    logic [15:0] m_dq;
    bit          m_full, m_ovr;
    logic [2:0]  m_prev;

    task automatic model_reset();
        ecnt = 0; t_acc = 0; acc_valid = 0;
        m_addr = '0; m_end = '0; m_dq = '0; m_full = 0; m_ovr = 0; m_prev = S_IDLE;
        wq.delete();
    endtask

    task automatic model_edge();
        logic [2:0] st;
        bit rec, newrec, busy;
        int age;
        ecnt++;
        st     = (i_state > 3'd3) ? S_IDLE : i_state;
        rec    = (st == S_REC);
        newrec = rec && !(m_prev == S_REC || m_prev == S_PAUSE);
        age    = ecnt - t_acc;
        busy   = acc_valid && age >= 1 && age <= 3;
        if (acc_valid && age == 2) m_end = m_addr;
        if (acc_valid && age == 3) begin
            if (m_addr == MAX) m_full = 1;
            else               m_addr = m_addr + 1;
        end
        if (newrec) begin
            m_addr = '0; m_end = '0; m_full = 0; m_ovr = 0;
        end
        if (i_write_enable && rec) begin
            if (busy) m_ovr = 1;
            else if (!m_full) begin
                acc_valid = 1; t_acc = ecnt; m_dq = i_write_data;
                wq.push_back('{a: m_addr, d: i_write_data});
            end
        end
        m_prev = st;
    endtask

    task automatic check_cycle();
        int age;
        bit e_oe, e_wen, e_done;
        wr_t w;
        age    = ecnt - t_acc;
        e_oe   = acc_valid && age <= 2;
        e_wen  = !(acc_valid && age == 1);
        e_done = acc_valid && age == 2;
        chk("addr", SRAM_ADDR, m_addr);
        chk("dq", o_sram_dq, m_dq);
        chk("oe", o_sram_dq_oe, e_oe);
        chk("ctrl", o_sram_ctrl, {e_wen, 4'b0100});
        chk("done", o_write_done, e_done);
        chk("end_addr", o_record_end_addr, m_end);
        chk("full", o_mem_full, m_full);
`ifdef SRAM_WR_OVERRUN_EN
        chk("overrun", o_overrun, m_ovr);
`endif
        // SRAM-side scoreboard: every WE_N low cycle must match the next
        // expected write in order.
        if (o_sram_ctrl[4] == 1'b0) begin
            n_wr++;
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                w = wq.pop_front();
                chk("wr_addr", SRAM_ADDR, w.a);
                chk("wr_data", o_sram_dq, w.d);
            end
        end
    endtask

    task automatic cyc(input logic [2:0] st, input logic we, input logic [15:0] d);
        i_state = st; i_write_enable = we; i_write_data = d;
        @(posedge i_clk);
        if (i_rst_n) model_edge();
        @(negedge i_clk);
        check_cycle();
    endtask

    task automatic hold(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) cyc(st, 1'b0, 16'h0);
    endtask

    logic [2:0] cur;
    int r, wr0;

    initial begin
        i_rst_n = 1'b0; i_state = S_IDLE; i_write_enable = 1'b0; i_write_data = '0;
        model_reset();
        @(negedge i_clk); @(negedge i_clk);
        check_cycle();
        chk("reset_ctrl", o_sram_ctrl, 5'b10100);
        i_rst_n = 1'b1;

        // Three samples 6 cycles apart from IDLE -> addresses 0,1,2.
        hold(S_IDLE, 2);
        cyc(S_REC, 1, 16'hff00); hold(S_REC, 5);
        cyc(S_REC, 1, 16'hff01); hold(S_REC, 5);
        cyc(S_REC, 1, 16'hff02); hold(S_REC, 5);
        chk("three_end_addr", o_record_end_addr, 20'd2);

        // Second pulse 2 cycles after the first is dropped.
        hold(S_IDLE, 2);
        wr0 = n_wr;
        cyc(S_REC, 1, 16'h1111); cyc(S_REC, 0, 0);
        cyc(S_REC, 1, 16'h2222); hold(S_REC, 6);
        chk("overrun_writes", n_wr - wr0, 1);
        chk("overrun_end", o_record_end_addr, 20'd0);
`ifdef SRAM_WR_OVERRUN_EN
        chk("overrun_flag", o_overrun, 1);
`endif

        // Fill: five pulses with MAX_ADDR=3.
        hold(S_IDLE, 2);
        wr0 = n_wr;
        for (int i = 0; i < 5; i++) begin
            cyc(S_REC, 1, 16'h5a00 + 16'(i)); hold(S_REC, 5);
        end
        chk("fill_writes", n_wr - wr0, 4);
        chk("fill_full", o_mem_full, 1);
        chk("fill_addr", SRAM_ADDR, MAX);

        // Pause/resume continues contiguously; IDLE->RECORD restarts.
        hold(S_IDLE, 2);
        cyc(S_REC, 1, 16'hc000); hold(S_REC, 5);
        cyc(S_REC, 1, 16'hc001); hold(S_REC, 5);
        cyc(S_PAUSE, 1, 16'hdead); hold(S_PAUSE, 3);
        cyc(S_REC, 1, 16'hc002); hold(S_REC, 5);
        chk("pause_end", o_record_end_addr, 20'd2);
        hold(S_IDLE, 2);
        cyc(S_REC, 0, 0);
        chk("restart_addr", SRAM_ADDR, 20'd0);
        chk("restart_full", o_mem_full, 0);

        // Asynchronous reset in the middle of the strobe.
        hold(S_IDLE, 2);
        cyc(S_REC, 1, 16'h1234);
        cyc(S_REC, 0, 0);
        chk("strobe_before_rst", o_sram_ctrl, 5'b00100);
        #2 i_rst_n = 1'b0;
        #1 chk("rst_async_ctrl", o_sram_ctrl, 5'b10100);
        model_reset();
        check_cycle();
        @(negedge i_clk);
        check_cycle();
        i_rst_n = 1'b1;

        // Leaving RECORD during setup: the write still completes.
        hold(S_IDLE, 2);
        wr0 = n_wr;
        cyc(S_REC, 1, 16'h7777);
        cyc(S_PLAY, 0, 0);
        cyc(S_PLAY, 0, 0);
        chk("play_done", o_write_done, 1);
        cyc(S_PLAY, 1, 16'h8888); hold(S_PLAY, 5);
        cyc(S_PLAY, 1, 16'h9999); hold(S_PLAY, 5);
        chk("play_writes", n_wr - wr0, 1);

        // Randomised run.
        cur = S_REC;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 19);
                if (r < 12)      cur = S_REC;
                else if (r < 15) cur = S_PAUSE;
                else if (r < 17) cur = S_IDLE;
                else if (r < 19) cur = S_PLAY;
                else             cur = 3'($urandom_range(4, 7));
            end
            cyc(cur, $urandom_range(0, 2) == 0, 16'($urandom));
        end
        hold(S_IDLE, 5);
        chk("queue_drained", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_record_writer.md
# sram_record_writer

Record-path SRAM writer for the audio recorder. Takes 16-bit samples handed over by the I2S receiver while the top-level FSM is in RECORD and writes them to consecutive SRAM addresses, starting at 0. Each sample gets a three-phase write cycle: setup, write strobe, hold. It publishes the last written address so the playback reader knows where the recording ends. Sits beside the playback reader; the top level muxes SRAM address, data and control between the two by state.

## Interface
- MAX_ADDR, default 20'hFFFFF: highest SRAM address the writer may use.
- i_clk  in  1  12 MHz system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_state  in  3  top FSM state: 3'b000 IDLE, 3'b001 PLAY, 3'b010 RECORD, 3'b011 PAUSE; other codes are treated as IDLE.
- i_write_enable  in  1  one-cycle pulse from I2S; i_write_data is valid in the same cycle.
- i_write_data  in  16  signed PCM sample.
- SRAM_ADDR  out  20  SRAM address.
- o_sram_dq  out  16  write data for the SRAM DQ bus.
- o_sram_dq_oe  out  1  DQ tristate enable.
- o_sram_ctrl  out  5  {WE_N, CE_N, OE_N, LB_N, UB_N}.
- o_write_done  out  1  one-cycle pulse when a sample has been committed.
- o_record_end_addr  out  20  address of the last committed sample.
- o_mem_full  out  1  high once MAX_ADDR has been written.
- o_overrun  out  1  sticky flag for a dropped sample; present only when SRAM_WR_OVERRUN_EN is defined.

## Operation
- Write FSM states: W_IDLE → W_SETUP → W_STROBE → W_HOLD → W_IDLE.
- Accept condition in W_IDLE: i_write_enable=1, i_state=RECORD and o_mem_full=0.
  - On accept: latch data into o_sram_dq and go to W_SETUP.
- W_SETUP: SRAM_ADDR and o_sram_dq are stable; o_sram_dq_oe=1; WE_N=1.
- W_STROBE: WE_N=0; all other outputs are held.
- W_HOLD: WE_N=1; o_sram_dq_oe=1; o_write_done=1; o_record_end_addr ← SRAM_ADDR.
  - If SRAM_ADDR==MAX_ADDR: set o_mem_full and keep SRAM_ADDR unchanged.
  - Otherwise SRAM_ADDR increments by 1 at the end of the cycle.
- o_sram_ctrl is 5'b10100 in every state except W_STROBE, where it is 5'b00100. o_sram_dq_oe=0 in W_IDLE.
- New recording: i_state becomes RECORD while the previous registered state was not RECORD or PAUSE.
  - In that cycle: SRAM_ADDR←0, o_record_end_addr←0, o_mem_full←0, o_overrun←0.
  - A sample pulse in that same cycle is accepted and written to address 0.
- PAUSE, or RECORD entered from PAUSE: address and flags are held, so the recording continues contiguously. No writes are accepted in PAUSE.
- Leaving RECORD while a write is in flight (W_SETUP, W_STROBE or W_HOLD): the write completes normally. Pulses arriving outside RECORD are ignored silently.
- Pulse while not in W_IDLE during RECORD: the sample is dropped and o_overrun sets.
- Pulse in RECORD with o_mem_full=1: the sample is dropped, and o_overrun does not set.
- o_record_end_addr holds its value outside RECORD, for use by the reader.

## Timing
- Reset values: FSM in W_IDLE; SRAM_ADDR=0; o_sram_dq=0; o_sram_dq_oe=0; o_sram_ctrl=5'b10100; o_write_done=0; o_record_end_addr=0; o_mem_full=0; o_overrun=0.
- Reset is asynchronous: WE_N returns high immediately, including mid-strobe.
- If a sample is accepted at edge N:
  - W_SETUP is visible after edge N.
  - WE_N is low for exactly one cycle, after edge N+1.
  - o_write_done and the updated o_record_end_addr are visible after edge N+2.
  - The incremented address and W_IDLE are visible after edge N+3.
- Throughput is 1 sample per 4 cycles, which is far above the audio rate.
- Address and data are stable for one full cycle on each side of the WE_N low pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SRAM_WR_OVERRUN_EN defined: the o_overrun port and its sticky logic are present. o_overrun clears only on reset or at the start of a new recording.
- SRAM_WR_OVERRUN_EN undefined: the o_overrun port is absent and dropped samples are not reported. All other behaviour is identical.

## Test plan
- Reset, then RECORD from IDLE with three pulses of 16'hff00, 16'hff01, 16'hff02, 6 cycles apart → writes at addresses 0, 1, 2. Each write has exactly one WE_N low cycle, with matching o_sram_dq. Final o_record_end_addr=2.
- Pulse, then a second pulse 2 cycles later → only the first sample is written; o_overrun=1 (macro on), and the port is absent with the macro off.
- MAX_ADDR=20'h00003, five pulses → writes to 0..3; o_mem_full=1; SRAM_ADDR stays at 3; the fifth pulse causes no WE_N activity.
- Two samples, then PAUSE, then RECORD, then one sample → third write goes to address 2. Then IDLE→RECORD → address restarts at 0 and flags clear.
- i_rst_n low during W_STROBE → o_sram_ctrl=5'b10100 in the same cycle; all outputs at their reset values.
- Change i_state to PLAY during W_SETUP → the write completes at the current address with o_write_done=1; later pulses are ignored.
